// File: rtl/acc_diff_arbiter.sv
// Round-robin arbiter sharing one accumulate-difference datapath among NCH channels.
// Each channel keeps its own context. A completion pulse is raised when a context passes THRESH.
module acc_diff_arbiter #(
  parameter int NCH    = 4,
  parameter int DW     = 4,
  parameter int RW     = 8,
  parameter int THRESH = 127
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*DW-1:0]        a_bus,
  input  logic [NCH*DW-1:0]        b_bus,
  input  logic                     flush,
  output logic [NCH-1:0]           gnt,
  output logic                     valid,
  output logic [$clog2(NCH)-1:0]   valid_ch,
  output logic [RW-1:0]            result
);

  localparam int CW = $clog2(NCH);

  logic [CW-1:0] ptr;
  logic [CW-1:0] sel;
  logic          any_req;
  logic          xfer;

  logic          s1_vld;
  logic [CW-1:0] s1_ch;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;

  logic [RW-1:0] ctx [NCH];
  logic [RW-1:0] cur;
  logic [RW:0]   sum;
  logic          pos_diff;
  logic          over;

  // Search starts at ptr; CW-bit index arithmetic wraps modulo NCH.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt     = '0;
    sel     = ptr;
    any_req = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!any_req && req[ptr + CW'(k)]) begin
        any_req = 1'b1;
        sel     = ptr + CW'(k);
      end
    end
    if (any_req && !flush && rst_n) gnt[sel] = 1'b1;
  end

  assign xfer = |gnt;

  // Stage-2 arithmetic: one extra bit so the threshold compare never wraps.
  always_comb begin
    cur      = ctx[s1_ch];
    pos_diff = s1_a > s1_b;
    sum      = {1'b0, cur} + {{(RW + 1 - DW){1'b0}}, s1_a - s1_b};
    over     = sum > (RW + 1)'(THRESH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_vld   <= 1'b0;
      s1_ch    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      valid    <= 1'b0;
      valid_ch <= '0;
      result   <= '0;
      // NOTE: the context array is small and must be cleared by reset and flush, so it is built from resettable flops, not RAM.
      for (int i = 0; i < NCH; i++) ctx[i] <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      valid  <= 1'b0;
      for (int i = 0; i < NCH; i++) ctx[i] <= '0;
    end else begin
      s1_vld <= xfer;
      valid  <= 1'b0;
      if (xfer) begin
        ptr   <= sel + CW'(1);
        s1_ch <= sel;
        s1_a  <= a_bus[sel*DW +: DW];
        s1_b  <= b_bus[sel*DW +: DW];
      end
      // Pairs with A <= B are consumed without touching the context.
      if (s1_vld && pos_diff) begin
        if (over) begin
          ctx[s1_ch] <= '0;
          valid      <= 1'b1;
          result     <= sum[RW-1:0];
          valid_ch   <= s1_ch;
        end else begin
          ctx[s1_ch] <= sum[RW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_diff_arbiter.sv
// Self-checking bench for acc_diff_arbiter: directed table, hand-written corner sequences,
// and randomized traffic compared against an arithmetic reference model.
module tb_acc_diff_arbiter;

  localparam int NCH    = 4;
  localparam int DW     = 4;
  localparam int RW     = 8;
  localparam int THRESH = 127;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req   = '0;
  logic [NCH*DW-1:0] a_bus = '0;
  logic [NCH*DW-1:0] b_bus = '0;
  logic              flush = 1'b0;
  logic [NCH-1:0]    gnt;
  logic              valid;
  logic [1:0]        valid_ch;
  logic [RW-1:0]     result;

  always #5 clock = ~clock;

  acc_diff_arbiter #(.NCH(NCH), .DW(DW), .RW(RW), .THRESH(THRESH)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .req      (req),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .flush    (flush),
    .gnt      (gnt),
    .valid    (valid),
    .valid_ch (valid_ch),
    .result   (result)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;
  logic [NCH-1:0] seen_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per-channel totals, a pointer and one pending pair.
  int m_ctx [NCH];
  int m_ptr;
  bit m_pv;
  int m_pch, m_pa, m_pb;
  bit m_valid;
  int m_ch, m_res;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) m_ctx[i] = 0;
    m_ptr = 0; m_pv = 0; m_pch = 0; m_pa = 0; m_pb = 0;
    m_valid = 0; m_ch = 0; m_res = 0;
  endfunction

  function automatic int model_pick(input logic [NCH-1:0] r, input logic f);
    if (f) return -1;
    for (int k = 0; k < NCH; k++)
      if (r[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    return -1;
  endfunction

  function automatic void model_edge(input int g, input logic f,
                                     input logic [NCH*DW-1:0] a, input logic [NCH*DW-1:0] b);
    int s;
    if (f) begin
      for (int i = 0; i < NCH; i++) m_ctx[i] = 0;
      m_pv = 0; m_valid = 0;
      return;
    end
    m_valid = 0;
    if (m_pv && m_pa > m_pb) begin
      s = m_ctx[m_pch] + m_pa - m_pb;
      if (s > THRESH) begin
        m_ctx[m_pch] = 0; m_valid = 1; m_res = s; m_ch = m_pch;
      end else begin
        m_ctx[m_pch] = s;
      end
    end
    m_pv = (g >= 0);
    if (g >= 0) begin
      m_pch = g;
      m_pa  = int'(a[g*DW +: DW]);
      m_pb  = int'(b[g*DW +: DW]);
      m_ptr = (g + 1) % NCH;
    end
  endfunction

  // One clock: drive, check gnt, clock edge, check registered outputs.
  task automatic run_cycle(input logic [NCH-1:0] r, input logic [NCH*DW-1:0] a,
                           input logic [NCH*DW-1:0] b, input logic f, output int g);
    logic [NCH-1:0] eg;
    req = r; a_bus = a; b_bus = b; flush = f;
    #1;
    g  = model_pick(r, f);
    eg = (g >= 0) ? NCH'(1 << g) : '0;
    seen_gnt = gnt;
    check("gnt", 32'(gnt), 32'(eg));
    @(posedge clock);
    model_edge(g, f, a, b);
    @(negedge clock);
    if (valid === 1'b1) n_pulse++;
    check("valid", 32'(valid), 32'(m_valid));
    check("valid_ch", 32'(valid_ch), 32'(m_ch));
    check("result", 32'(result), 32'(m_res));
  endtask

  function automatic logic [NCH*DW-1:0] lane(input int ch, input int v);
    logic [NCH*DW-1:0] w;
    w = '0;
    w[ch*DW +: DW] = DW'(v);
    return w;
  endfunction

  typedef struct {
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] a;
    logic [NCH*DW-1:0] b;
    logic [NCH-1:0]    gnt;
    logic              vld;
    logic [1:0]        ch;
    logic [RW-1:0]     res;
  } vec_t;

  vec_t tbl [11];
  int   g;
  int   p0;
  logic [NCH-1:0]    h_req;
  logic [NCH*DW-1:0] h_a, h_b;
  logic              h_f;

  initial begin
    // Single-channel accumulation: 9 transfers of 15, completion one cycle after the 9th.
    for (int i = 0; i < 11; i++) begin
      tbl[i].req = (i < 9) ? 4'b0001 : 4'b0000;
      tbl[i].a   = (i < 9) ? lane(0, 15) : '0;
      tbl[i].b   = '0;
      tbl[i].gnt = tbl[i].req;
      tbl[i].vld = (i == 9);
      tbl[i].ch  = 2'd0;
      tbl[i].res = (i >= 9) ? 8'd135 : 8'd0;
    end

    // Reset state, with requests pending to show gnt is forced low.
    model_reset();
    req = 4'b1111;
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_valid_ch", 32'(valid_ch), 0);
    @(negedge clock);
    rst_n = 1'b1;
    req   = '0;

    for (int i = 0; i < 11; i++) begin
      run_cycle(tbl[i].req, tbl[i].a, tbl[i].b, 1'b0, g);
      check($sformatf("tbl%0d_gnt", i), 32'(seen_gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].vld));
      check($sformatf("tbl%0d_ch", i), 32'(valid_ch), 32'(tbl[i].ch));
      check($sformatf("tbl%0d_result", i), 32'(result), 32'(tbl[i].res));
    end

    // Qualification: A<=B pairs are discarded, 8 + 8*15 = 128 completes.
    p0 = n_pulse;
    run_cycle(4'b0010, lane(1, 3), lane(1, 3), 1'b0, g);
    run_cycle(4'b0010, lane(1, 2), lane(1, 9), 1'b0, g);
    run_cycle(4'b0010, lane(1, 10), lane(1, 2), 1'b0, g);
    check("qual_no_pulse", 32'(n_pulse - p0), 0);
    for (int i = 0; i < 8; i++) run_cycle(4'b0010, lane(1, 15), '0, 1'b0, g);
    run_cycle('0, '0, '0, 1'b0, g);
    check("qual_pulses", 32'(n_pulse - p0), 1);
    check("qual_ch", 32'(valid_ch), 1);
    check("qual_result", 32'(result), 128);

    // Round-robin: move ptr to 0, then hold all four requests.
    run_cycle(4'b1000, '0, '0, 1'b0, g);
    for (int i = 0; i < 5; i++) begin
      run_cycle(4'b1111, '0, '0, 1'b0, g);
      check($sformatf("rr%0d_gnt", i), 32'(seen_gnt), 32'(1 << (i % 4)));
    end
    run_cycle(4'b0010, '0, '0, 1'b0, g);
    run_cycle(4'b0011, '0, '0, 1'b0, g);
    check("rr_wrap_gnt", 32'(seen_gnt), 32'b0001);

    // Interleaved contexts on ch2/ch3, diff 14 each, completing on consecutive cycles.
    for (int i = 0; i < 22; i++) begin
      run_cycle((i < 20) ? 4'b1100 : 4'b0000, lane(2, 15) | lane(3, 15),
                lane(2, 1) | lane(3, 1), 1'b0, g);
      if (i == 19) begin
        check("il_first_valid", 32'(valid), 1);
        check("il_first_ch", 32'(valid_ch), 2);
        check("il_first_result", 32'(result), 140);
      end
      if (i == 20) begin
        check("il_second_valid", 32'(valid), 1);
        check("il_second_ch", 32'(valid_ch), 3);
        check("il_second_result", 32'(result), 140);
      end
    end

    // Flush with ctx0=120 and a pending 15: no pulse, contexts cleared.
    for (int i = 0; i < 9; i++) run_cycle(4'b0001, lane(0, 15), '0, 1'b0, g);
    p0 = n_pulse;
    run_cycle(4'b0001, lane(0, 15), '0, 1'b1, g);
    check("flush_gnt", 32'(seen_gnt), 0);
    check("flush_valid", 32'(valid), 0);
    check("flush_result_held", 32'(result), 140);
    for (int i = 0; i < 9; i++) run_cycle(4'b0001, lane(0, 15), '0, 1'b0, g);
    check("flush_no_early_pulse", 32'(n_pulse - p0), 0);
    run_cycle('0, '0, '0, 1'b0, g);
    check("post_flush_valid", 32'(valid), 1);
    check("post_flush_result", 32'(result), 135);

    // Async reset between edges with a pulse visible and a pair in flight.
    for (int i = 0; i < 10; i++) run_cycle(4'b0010, lane(1, 15), '0, 1'b0, g);
    check("pre_rst_valid", 32'(valid), 1);
    check("pre_rst_ch", 32'(valid_ch), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_ch", 32'(valid_ch), 0);
    check("arst_result", 32'(result), 0);
    check("arst_gnt", 32'(gnt), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_cycle(4'b1010, lane(1, 15) | lane(3, 15), '0, 1'b0, g);
    check("post_rst_gnt", 32'(seen_gnt), 32'b0010);

    // Randomized traffic; requesters hold req and operands until granted.
    h_req = '0; h_a = '0; h_b = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!h_req[c] && ($urandom_range(1, 0) == 1)) begin
          h_req[c] = 1'b1;
          h_a[c*DW +: DW] = DW'($urandom_range(15, 0));
          h_b[c*DW +: DW] = DW'($urandom_range(15, 0));
        end
      end
      h_f = ($urandom_range(31, 0) == 0);
      run_cycle(h_req, h_a, h_b, h_f, g);
      if (g >= 0) h_req[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_diff_arbiter.md
# acc_diff_arbiter

Round-robin scheduler that shares one accumulate-difference datapath among NCH requester channels. Each channel keeps its own accumulator context. Each channel offers (A, B) operand pairs through a req/gnt handshake. The block grants one channel per cycle, accumulates A − B into that channel's context only when A > B, and emits a one-cycle valid with channel id and total when a context exceeds THRESH. It sits between the capture front-ends and downstream result consumers, replacing per-channel accumulators.

## Interface
- NCH, 4, number of requester channels (≥2, power of 2)
- DW, 4, operand width, unsigned
- RW, 8, result/context width, unsigned; requires THRESH + 2^DW − 1 < 2^RW
- THRESH, 127, a context strictly greater than this completes an accumulation
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NCH  per-channel request; channel holds it and its operands stable until granted
- a_bus  in  NCH*DW  channel i A operand at [i*DW +: DW]
- b_bus  in  NCH*DW  channel i B operand at [i*DW +: DW]
- flush  in  1  synchronous clear of all contexts and of the pipeline
- gnt  out  NCH  one-hot or zero, combinational from req, pointer, flush, rst_n
- valid  out  1  registered one-cycle pulse: accumulation complete
- valid_ch  out  log2(NCH)  channel that completed; held between pulses
- result  out  RW  completed total; held between pulses

## Operation
- Arbitration: round-robin pointer ptr; reset value 0. gnt selects the first channel with req=1 searching ptr, ptr+1, … mod NCH.
- gnt=0 when no req, when flush=1, or when rst_n=0.
- Transfer: a rising edge with req[i] & gnt[i]. After a transfer to channel i, ptr <= (i+1) mod NCH. ptr is unchanged when there is no transfer.
- Stage 1 register, loaded at the transfer edge: s1_vld, s1_ch, s1_a, s1_b. s1_vld=0 on any edge without a transfer.
- Stage 2 executes at the next edge when s1_vld=1. Let c = ctx[s1_ch].
  - If s1_a ≤ s1_b: ctx is unchanged and valid=0. The operand pair is consumed and discarded.
  - Otherwise compute sum = c + (s1_a − s1_b) at RW+1 bits.
    - If sum > THRESH: ctx[s1_ch] <= 0, valid <= 1, result <= sum[RW-1:0], valid_ch <= s1_ch.
    - Otherwise: ctx[s1_ch] <= sum and valid <= 0.
- Invariant: every ctx ≤ THRESH at all times.
- No hazard on back-to-back transfers from the same channel. The ctx write at edge E1 is visible to the stage-2 read at E2.
- flush=1 at an edge clears all ctx, s1_vld and valid. flush beats a pending stage-2 op (no valid pulse). result, valid_ch and ptr are unchanged.
- Reset (asynchronous): ctx=0, ptr=0, s1_vld=0, valid=0, valid_ch=0, result=0, gnt=0.
- Reset during an operation discards the in-flight pair and all contexts.

## Timing
- gnt: zero-cycle, combinational in the same cycle as req.
- Operands are sampled at the transfer edge E0.
- Latency: valid is high in the cycle after edge E1 = E0+1 clock. It lasts exactly one cycle unless the next stage-2 op also completes.
- Throughput: one transfer per clock across all channels.
- Fairness: under continuous requests from k channels, each channel is granted once every k cycles.
- valid may pulse on consecutive cycles for different channels, or for the same channel.

## Test plan
- Single channel: ch0 req with A=15, B=0 each cycle for 9 transfers. Context goes 15, 30, …, 120. The 9th transfer gives sum=135 >127, so valid pulses 1 cycle after that transfer edge with valid_ch=0, result=135, and ctx0 returns to 0.
- Qualification: ch1 A=3, B=3, then A=2, B=9. Both are granted and valid never asserts. Then A=10, B=2 gives ctx1=8. A subsequent total of 8+120=128 yields result=128, proving discarded pairs left ctx untouched.
- Round-robin: req=4'b1111 held. gnt sequence is 0001, 0010, 0100, 1000, 0001. With ptr=2 and req=4'b0011, gnt=0001.
- Interleaved contexts: ch2 and ch3 alternate, each with A=15, B=1 (diff 14). Each context independently completes at its 10th transfer (sum 140). valid_ch alternates 2, 3 on consecutive valid cycles.
- flush: ch0 ctx=120 with a pair A=15, B=0 in stage 1 while flush=1. No valid pulse, all ctx=0, and gnt=0 during flush. The next ch0 A=15, B=0 gives ctx=15.
- Async reset: assert rst_n=0 mid-stream, between clock edges. Outputs go to 0 immediately and gnt=0. After release, ptr=0, and with req=4'b1010 channel 1 is granted first.
